// File: rtl/ram_cmd_master.sv
// Command initiator for the single-port RAM: turns valid/ready read/write requests
// into {opcode, payload} command strobes and returns read data as a one-cycle response.
module ram_cmd_master #(
  parameter int ADDR_SIZE     = 8,
  parameter int DATA_SIZE     = 8,
  parameter int TIMEOUT       = 4,
  parameter int ADDR_CACHE_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  input  logic                 cache_flush,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 rsp_error,
  output logic [((ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE)+1:0] din,
  output logic                 rx_valid,
  input  logic                 tx_valid,
  input  logic [DATA_SIZE-1:0] dout
);

  localparam int PAY_W = (ADDR_SIZE > DATA_SIZE) ? ADDR_SIZE : DATA_SIZE;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  logic [1:0]           state_r;
  logic                 write_r;
  logic [ADDR_SIZE-1:0] addr_r;
  logic [DATA_SIZE-1:0] wdata_r;
  logic [ADDR_SIZE-1:0] wr_addr_c_r;
  logic [ADDR_SIZE-1:0] rd_addr_c_r;
  logic                 wr_ok_r;
  logic                 rd_ok_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 handshake_s;
  logic                 hit_s;
  logic                 miss_issue_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic                 timeout_s;
  logic                 timeout_evt_s;

  function automatic logic [PAY_W-1:0] pad_addr(input logic [ADDR_SIZE-1:0] a);
    logic [PAY_W-1:0] p;
    p = {PAY_W{1'b0}};
    p[ADDR_SIZE-1:0] = a;
    return p;
  endfunction

  function automatic logic [PAY_W-1:0] pad_data(input logic [DATA_SIZE-1:0] d);
    logic [PAY_W-1:0] p;
    p = {PAY_W{1'b0}};
    p[DATA_SIZE-1:0] = d;
    return p;
  endfunction

  // Data-phase command for a request: write data, or a read-data fetch.
  function automatic logic [PAY_W+1:0] data_cmd(input logic wr, input logic [DATA_SIZE-1:0] d);
    if (wr) begin
      return {OP_WDATA, pad_data(d)};
    end else begin
      return {OP_RDATA, {PAY_W{1'b0}}};
    end
  endfunction

  assign req_ready   = (state_r == ST_IDLE) && !rst;
  assign handshake_s = req_valid && req_ready;
  assign cnt_inc_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout_s   = (cnt_inc_s == CNT_W'(TIMEOUT));

  // Address-cache lookup and cache/timeout event decode.
  always_comb begin
    hit_s         = 1'b0;
    miss_issue_s  = 1'b0;
    timeout_evt_s = 1'b0;
    if (ADDR_CACHE_EN != 0) begin
      if (req_write) begin
        hit_s = wr_ok_r && (wr_addr_c_r == req_addr);
      end else begin
        hit_s = rd_ok_r && (rd_addr_c_r == req_addr);
      end
    end else begin
      hit_s = 1'b0;
    end
    miss_issue_s = handshake_s && !hit_s;
    if ((state_r == ST_WAIT) && !tx_valid && timeout_s) begin
      timeout_evt_s = 1'b1;
    end else begin
      timeout_evt_s = 1'b0;
    end
  end

  // Cached write/read addresses; flush and reset win over a set in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || cache_flush) begin
      wr_ok_r     <= 1'b0;
      rd_ok_r     <= 1'b0;
      wr_addr_c_r <= {ADDR_SIZE{1'b0}};
      rd_addr_c_r <= {ADDR_SIZE{1'b0}};
    end else begin
      if (miss_issue_s && req_write) begin
        wr_ok_r     <= 1'b1;
        wr_addr_c_r <= req_addr;
      end
      if (miss_issue_s && !req_write) begin
        rd_ok_r     <= 1'b1;
        rd_addr_c_r <= req_addr;
      end
      if (timeout_evt_s) begin
        rd_ok_r <= 1'b0;
      end
    end
  end

  // Request FSM; din/rx_valid are loaded on the edge that enters the command's state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      write_r   <= 1'b0;
      addr_r    <= {ADDR_SIZE{1'b0}};
      wdata_r   <= {DATA_SIZE{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      din       <= {(PAY_W+2){1'b0}};
      rx_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_SIZE{1'b0}};
      rsp_error <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            write_r  <= req_write;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            rx_valid <= 1'b1;
            if (hit_s) begin
              state_r <= ST_DATA;
              din     <= data_cmd(req_write, req_wdata);
            end else begin
              state_r <= ST_ADDR;
              din     <= {(req_write ? OP_WADDR : OP_RADDR), pad_addr(req_addr)};
            end
          end
        end
        ST_ADDR: begin
          state_r  <= ST_DATA;
          rx_valid <= 1'b1;
          din      <= data_cmd(write_r, wdata_r);
        end
        ST_DATA: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= write_r ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_valid) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= dout;
            state_r   <= ST_IDLE;
          end else if (timeout_s) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= {DATA_SIZE{1'b0}};
            cnt_r     <= cnt_inc_s;
            state_r   <= ST_IDLE;
          end else if (cnt_r != CNT_W'(TIMEOUT)) begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
